// File: rtl/store_narrow_rmw_pkg.sv
// Shared definitions for the store narrowing unit: size encodings, FSM states
// and the alignment rule applied when a store is accepted.
package store_narrow_rmw_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    // Illegal size encodings count as misaligned so they take the error path.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Little-endian sub-word merge: drops the narrowed store data into its byte
// lanes of the old memory word, keeping every other lane.
module store_lane_merge
    import store_narrow_rmw_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [15:0] data,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        case (size)
            SZ_BYTE: merged[{addr_lo, 3'b000} +: 8]       = data[7:0];
            SZ_HALF: merged[{addr_lo[1], 4'b0000} +: 16]  = data;
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_narrow_rmw.sv
// Store-path narrowing unit: word stores are written straight through, byte and
// halfword stores read the target word, merge the new lanes and write it back.
module store_narrow_rmw
    import store_narrow_rmw_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_data_i,
    input  logic [1:0]    req_size_i,
    output logic          done_o,
    output logic          err_o,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_rd_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_rvalid_i,
    output logic          mem_wr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_wack_i
);

    state_e        state;
    logic [15:0]   data_q;
    logic [1:0]    size_q;
    logic [1:0]    lo_q;
    logic          err_q;
    logic [DW-1:0] merged;
    logic          accept;
    logic          bad;

    assign req_ready_o = (state == ST_IDLE) && !rst_i;
    assign accept      = req_valid_i && req_ready_o;
    assign bad         = misaligned(req_size_i, req_addr_i[1:0]);

    assign mem_rd_o = (state == ST_RD);
    assign mem_wr_o = (state == ST_WR);
    assign done_o   = (state == ST_FIN);
    assign err_o    = (state == ST_FIN) && err_q;

    // Merge operates on the live read data so the merged word is ready the
    // same cycle rvalid arrives.
    store_lane_merge u_merge (
        .old_word (mem_rdata_i),
        .data     (data_q),
        .addr_lo  (lo_q),
        .size     (size_q),
        .merged   (merged)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            err_q       <= 1'b0;
            data_q      <= '0;
            size_q      <= SZ_BYTE;
            lo_q        <= 2'b00;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        data_q <= req_data_i[15:0];
                        size_q <= req_size_i;
                        lo_q   <= req_addr_i[1:0];
                        err_q  <= bad;
                        if (bad) begin
                            state <= ST_FIN;
                        end else begin
                            mem_addr_o <= {req_addr_i[AW-1:2], 2'b00};
                            if (req_size_i == SZ_WORD) begin
                                mem_wdata_o <= req_data_i;
                                state       <= ST_WR;
                            end else begin
                                state <= ST_RD;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (mem_rvalid_i) begin
                        mem_wdata_o <= merged;
                        state       <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (mem_wack_i) state <= ST_FIN;
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Scoreboard bench for store_narrow_rmw with a stallable word memory model.
module tb_store_narrow_rmw;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_size = 2'b00;
    logic        done;
    logic        err;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata = '0;
    logic        mem_rvalid;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic        mem_wack;

    int rwait = 0;
    int wwait = 0;
    bit rv_noise = 1'b0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
    } wr_exp_t;

    wr_exp_t wr_q[$];
    logic    done_q[$];
    wr_exp_t mon_w;
    logic    mon_e;

    always #5 clk = ~clk;

    store_narrow_rmw #(.AW(32), .DW(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_data_i   (req_data),
        .req_size_i   (req_size),
        .done_o       (done),
        .err_o        (err),
        .mem_addr_o   (mem_addr),
        .mem_rd_o     (mem_rd),
        .mem_rdata_i  (mem_rdata),
        .mem_rvalid_i (mem_rvalid),
        .mem_wr_o     (mem_wr),
        .mem_wdata_o  (mem_wdata),
        .mem_wack_i   (mem_wack)
    );

    // Memory answers after the strobe has been held for rwait/wwait extra cycles.
    always @(posedge clk) begin
        rd_cnt <= mem_rd ? rd_cnt + 1 : 0;
        wr_cnt <= mem_wr ? wr_cnt + 1 : 0;
    end
    assign mem_rvalid = (mem_rd && rd_cnt >= rwait) || (rv_noise && !mem_rd);
    assign mem_wack   = mem_wr && wr_cnt >= wwait;

    // Scoreboard: every accepted write and every done pulse is checked against the queues.
    always @(negedge clk) begin
        if (mem_wr && mem_wack) begin
            n_cmp++;
            if (wr_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: addr=%h wdata=%h, required no write", mem_addr, mem_wdata);
            end else begin
                mon_w = wr_q.pop_front();
                if (mem_addr !== mon_w.addr || mem_wdata !== mon_w.wdata) begin
                    n_bad++;
                    $display("FAIL write_data: addr=%h wdata=%h, required addr=%h wdata=%h",
                             mem_addr, mem_wdata, mon_w.addr, mon_w.wdata);
                end
            end
        end
        if (done) begin
            n_cmp++;
            if (done_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: err=%b, required no done pulse", err);
            end else begin
                mon_e = done_q.pop_front();
                if (err !== mon_e) begin
                    n_bad++;
                    $display("FAIL done_err: err=%b, required %b", err, mon_e);
                end
            end
        end
        if (mem_rd || mem_wr) begin
            n_cmp++;
            if (mem_rd && mem_wr) begin
                n_bad++;
                $display("FAIL strobe_overlap: rd=%b wr=%b, required not both high", mem_rd, mem_wr);
            end
        end
    end

    // Drives one store and records, in cycles after the accept edge, when strobes and done appear.
    task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                             input logic [31:0] rdata, input int rw, input int ww,
                             input logic [31:0] exp_wdata, input logic exp_err,
                             output int k_rd, output int k_wr, output int k_done,
                             output int n_rd, output int n_wr,
                             output logic addr_moved, output logic wdata_moved);
        wr_exp_t     e;
        logic [31:0] a0;
        logic [31:0] w0;
        a0 = '0;
        w0 = '0;
        k_rd = -1; k_wr = -1; k_done = -1; n_rd = 0; n_wr = 0;
        addr_moved = 1'b0; wdata_moved = 1'b0;
        @(negedge clk);
        rwait = rw; wwait = ww; mem_rdata = rdata;
        req_valid = 1'b1; req_addr = a; req_data = d; req_size = s;
        if (!exp_err) begin
            e.addr  = {a[31:2], 2'b00};
            e.wdata = exp_wdata;
            wr_q.push_back(e);
        end
        done_q.push_back(exp_err);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_addr = ~a; req_data = ~d; req_size = ~s;
        for (int k = 1; k <= 24; k++) begin
            if (k > 1) @(negedge clk);
            if (mem_rd) begin
                if (k_rd < 0) begin k_rd = k; a0 = mem_addr; end
                n_rd++;
            end
            if (mem_wr) begin
                if (k_wr < 0) begin
                    k_wr = k; w0 = mem_wdata;
                    if (k_rd < 0) a0 = mem_addr;
                end
                n_wr++;
                if (mem_wdata !== w0) wdata_moved = 1'b1;
            end
            if ((mem_rd || mem_wr) && mem_addr !== a0) addr_moved = 1'b1;
            if (done) begin k_done = k; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({req_ready, done, err, mem_rd, mem_wr} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: ready/done/err/rd/wr=%b, required 00000",
                     {req_ready, done, err, mem_rd, mem_wr});
        end
        n_cmp++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_data: addr=%h wdata=%h, required 0/0", mem_addr, mem_wdata);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: ready=%b, required 1", req_ready);
        end
    endtask

    task automatic test_word();
        int k_rd, k_wr, k_done, n_rd, n_wr;
        logic am, wm;
        rv_noise = 1'b1;
        run_store(32'h100, 32'hDEADBEEF, 2'b10, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0,
                  k_rd, k_wr, k_done, n_rd, n_wr, am, wm);
        rv_noise = 1'b0;
        n_cmp++;
        if (k_wr !== 1 || k_done !== 2) begin
            n_bad++;
            $display("FAIL word_timing: wr@%0d done@%0d, required wr@1 done@2", k_wr, k_done);
        end
        n_cmp++;
        if (n_rd !== 0) begin
            n_bad++;
            $display("FAIL word_no_read: rd cycles=%0d, required 0", n_rd);
        end
    endtask

    task automatic test_byte();
        int k_rd, k_wr, k_done, n_rd, n_wr;
        logic am, wm;
        run_store(32'h203, 32'h123456AB, 2'b00, 32'h11223344, 0, 0, 32'hAB223344, 1'b0,
                  k_rd, k_wr, k_done, n_rd, n_wr, am, wm);
        n_cmp++;
        if (k_rd !== 1 || k_wr !== 2 || k_done !== 3) begin
            n_bad++;
            $display("FAIL byte_timing: rd@%0d wr@%0d done@%0d, required 1/2/3", k_rd, k_wr, k_done);
        end
        run_store(32'h201, 32'h000000AB, 2'b00, 32'h11223344, 0, 0, 32'h1122AB44, 1'b0,
                  k_rd, k_wr, k_done, n_rd, n_wr, am, wm);
        run_store(32'h400, 32'hFFFFFF55, 2'b00, 32'hFFFFFFFF, 0, 0, 32'hFFFFFF55, 1'b0,
                  k_rd, k_wr, k_done, n_rd, n_wr, am, wm);
        n_cmp++;
        if (k_done !== 3) begin
            n_bad++;
            $display("FAIL byte_lane0_done: done@%0d, required 3", k_done);
        end
    endtask

    task automatic test_half();
        int k_rd, k_wr, k_done, n_rd, n_wr;
        logic am, wm;
        run_store(32'h302, 32'hFFFF8001, 2'b01, 32'hAAAABBBB, 0, 0, 32'h8001BBBB, 1'b0,
                  k_rd, k_wr, k_done, n_rd, n_wr, am, wm);
        n_cmp++;
        if (k_done !== 3) begin
            n_bad++;
            $display("FAIL half_upper_done: done@%0d, required 3", k_done);
        end
        run_store(32'h500, 32'h0000CAFE, 2'b01, 32'h12345678, 0, 0, 32'h1234CAFE, 1'b0,
                  k_rd, k_wr, k_done, n_rd, n_wr, am, wm);
        n_cmp++;
        if (k_rd !== 1 || k_wr !== 2 || k_done !== 3) begin
            n_bad++;
            $display("FAIL half_lower_timing: rd@%0d wr@%0d done@%0d, required 1/2/3", k_rd, k_wr, k_done);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs [3];
        logic [1:0]  sizes [3];
        int k_rd, k_wr, k_done, n_rd, n_wr;
        logic am, wm;
        addrs[0] = 32'h101; sizes[0] = 2'b01;
        addrs[1] = 32'h102; sizes[1] = 2'b10;
        addrs[2] = 32'h100; sizes[2] = 2'b11;
        for (int i = 0; i < 3; i++) begin
            run_store(addrs[i], 32'hCAFEF00D, sizes[i], 32'h0, 0, 0, 32'h0, 1'b1,
                      k_rd, k_wr, k_done, n_rd, n_wr, am, wm);
            n_cmp++;
            if (k_done !== 1 || n_rd !== 0 || n_wr !== 0) begin
                n_bad++;
                $display("FAIL misaligned_%0d: done@%0d rd=%0d wr=%0d, required done@1 no strobes",
                         i, k_done, n_rd, n_wr);
            end
        end
    endtask

    task automatic test_stall();
        int k_rd, k_wr, k_done, n_rd, n_wr;
        logic am, wm;
        // rvalid arrives 3 cycles after the accept edge, wack 2 cycles after WR entry.
        run_store(32'h203, 32'h123456AB, 2'b00, 32'h11223344, 2, 2, 32'hAB223344, 1'b0,
                  k_rd, k_wr, k_done, n_rd, n_wr, am, wm);
        rwait = 0; wwait = 0;
        n_cmp++;
        if (k_rd !== 1 || k_wr !== 4 || k_done !== 7) begin
            n_bad++;
            $display("FAIL stall_timing: rd@%0d wr@%0d done@%0d, required 1/4/7", k_rd, k_wr, k_done);
        end
        n_cmp++;
        if (n_rd !== 3 || n_wr !== 3) begin
            n_bad++;
            $display("FAIL stall_strobes: rd cycles=%0d wr cycles=%0d, required 3/3", n_rd, n_wr);
        end
        n_cmp++;
        if (am !== 1'b0 || wm !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_stable: addr_moved=%b wdata_moved=%b, required 0/0", am, wm);
        end
    endtask

    task automatic test_reset_mid_op();
        int seen_wr, seen_done;
        seen_wr = 0; seen_done = 0;
        @(negedge clk);
        rwait = 100; mem_rdata = 32'h11223344;
        req_valid = 1'b1; req_addr = 32'h203; req_data = 32'h000000AB; req_size = 2'b00;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++;
        if (mem_rd !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_in_rd: rd=%b, required 1", mem_rd);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_ready_low: ready=%b, required 0", req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        rwait = 0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1 || mem_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_release: ready=%b rd=%b, required 1/0", req_ready, mem_rd);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_wr) seen_wr++;
            if (done) seen_done++;
        end
        n_cmp++;
        if (seen_wr !== 0 || seen_done !== 0) begin
            n_bad++;
            $display("FAIL midreset_abort: wr cycles=%0d done pulses=%0d, required 0/0", seen_wr, seen_done);
        end
    endtask

    task automatic test_back_to_back();
        wr_exp_t e;
        int kd1, ka, kd2;
        kd1 = -1; ka = -1; kd2 = -1;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h600; req_data = 32'h01020304; req_size = 2'b10;
        e.addr = 32'h600; e.wdata = 32'h01020304; wr_q.push_back(e); done_q.push_back(1'b0);
        @(posedge clk);
        @(negedge clk);
        req_addr = 32'h700; req_data = 32'hA5A5A5A5;
        e.addr = 32'h700; e.wdata = 32'hA5A5A5A5; wr_q.push_back(e); done_q.push_back(1'b0);
        for (int k = 1; k <= 24; k++) begin
            if (k > 1) @(negedge clk);
            if (ka >= 0) req_valid = 1'b0;
            if (done && kd1 < 0) kd1 = k;
            else if (done) kd2 = k;
            if (req_ready && req_valid && ka < 0) ka = k;
            if (kd2 >= 0) break;
        end
        req_valid = 1'b0;
        n_cmp++;
        if (kd1 !== 2 || ka !== 3) begin
            n_bad++;
            $display("FAIL b2b_accept: done1@%0d accept2@%0d, required 2/3", kd1, ka);
        end
        n_cmp++;
        if (kd2 !== 5) begin
            n_bad++;
            $display("FAIL b2b_done2: done2@%0d, required 5", kd2);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misaligned();
        test_stall();
        test_reset_mid_op();
        test_back_to_back();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (wr_q.size() != 0 || done_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: writes left=%0d dones left=%0d, required 0/0",
                     wr_q.size(), done_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/store_narrow_rmw.md
# store_narrow_rmw

Store-path narrowing unit for the single-cycle/multi-cycle CPU datapath, the counterpart of the load-side sign/zero extension. It takes a 32-bit register value plus a store size (byte/half/word), narrows it to the addressed sub-word, and commits it to a word-only data memory. Byte and halfword stores use a read-modify-write sequence. Word stores are written directly. It sits between the execute stage's store request and the data memory port.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width (fixed 4 byte lanes)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; **synchronous, active-high**
- req_valid_i  in  1  store request valid
- req_ready_o  out  1  unit idle, request accepted when valid&&ready
- req_addr_i  in  AW  byte address
- req_data_i  in  DW  register value to store
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle error pulse, coincident with done_o
- mem_addr_o  out  AW  word address, {addr[AW-1:2],2'b00}
- mem_rd_o  out  1  read strobe, held until mem_rvalid_i
- mem_rdata_i  in  DW  read data
- mem_rvalid_i  in  1  read data valid
- mem_wr_o  out  1  write strobe, held until mem_wack_i
- mem_wdata_o  out  DW  merged write word
- mem_wack_i  in  1  write accepted

## Operation
- States: IDLE, RD, WR, FIN.
- IDLE:
  - req_ready_o=1 when rst_i=0.
  - On accept, latch addr, data and size.
  - Alignment check on accept:
    - illegal size → error
    - half with addr[0]=1 → error
    - word with addr[1:0]≠0 → error
  - Error → FIN with error flag set; no memory access.
  - Aligned word → WR, with mem_wdata_o = req_data_i.
  - Aligned byte/half → RD.
- RD:
  - mem_rd_o=1.
  - On mem_rvalid_i, register the merged word and go to WR.
  - Merge is little-endian:
    - byte: lane addr[1:0] = data[7:0]
    - half: lanes {addr[1],1}:{addr[1],0} = data[15:0]
  - Other lanes are kept from mem_rdata_i. Upper bits of req_data_i are discarded.
- WR: mem_wr_o=1. On mem_wack_i go to FIN.
- FIN: done_o=1, err_o=error flag. Go to IDLE next cycle.
- Ignored inputs:
  - mem_rvalid_i outside RD
  - mem_wack_i outside WR
  - req_valid_i outside IDLE
- mem_addr_o and mem_wdata_o are stable from entry to RD/WR until leaving WR.
- Reset values: state IDLE; done_o, err_o, mem_rd_o, mem_wr_o = 0; mem_addr_o, mem_wdata_o = 0; req_ready_o=0 while rst_i=1.
- Reset mid-operation aborts at the next edge. No write is issued afterward, and no done_o pulse is produced.

## Timing
Request accepted at edge T; the memory responds in the same cycle it is strobed.
- Word store:
  - mem_wr_o high in cycle T+1
  - done_o in cycle T+2
  - next accept possible at T+3
- Byte/half store:
  - mem_rd_o in T+1
  - mem_wr_o in T+2
  - done_o in T+3
- Error: done_o and err_o in T+1, no strobes.
- Memory stalls extend RD/WR one cycle per cycle of missing rvalid/wack. Strobes remain asserted throughout.
- mem_rd_o and mem_wr_o are never high in the same cycle.

## Structure
- Shared package holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - state enum
  - misalignment check function
- Sub-module store_lane_merge is combinational: (old word, data, addr[1:0], size) → merged word.
- Expected size: about 150–250 lines including the sub-module.

## Test plan
- Word store, addr 0x100, data 0xDEADBEEF:
  - mem_wr_o at T+1 with mem_addr_o=0x100, mem_wdata_o=0xDEADBEEF
  - done_o at T+2, err_o=0
  - mem_rd_o never asserted
- Byte store, addr 0x203, data 0x123456AB, mem_rdata_i=0x11223344:
  - mem_addr_o=0x200
  - mem_wdata_o=0xAB223344
  - done_o at T+3
- Half store, addr 0x302, data 0xFFFF8001, mem_rdata_i=0xAAAABBBB:
  - mem_wdata_o=0x8001BBBB
- Misaligned cases each give err_o=done_o=1 at T+1 with no strobes:
  - half at addr 0x101
  - word at addr 0x102
  - size 11
- Stalls: byte store with mem_rvalid_i delayed 3 cycles and mem_wack_i delayed 2 cycles:
  - strobes held throughout
  - data stable
  - done_o at T+7
- Reset and back-to-back:
  - rst_i asserted during RD: no mem_wr_o, no done_o; req_ready_o=1 the cycle after rst_i drops.
  - Back-to-back requests with req_valid_i held high: second accept occurs the cycle after done_o.
